// File: rtl/bus_command_generator.sv
// Bus command generator: turns 8088 bus phases into IOR/IOW/MEMR/MEMW strobes
// with programmable strobe delay and wait states, and arbitrates hold requesters.
//
// Ports:
//   clock, reset_n        system clock, async active-low reset
//   cpu_clock_posedge     one-clock pulse at CPU clock rise
//   cpu_clock_negedge     one-clock pulse at CPU clock fall
//   RD_N, WR_N            CPU read / write request, active low
//   IO_OR_M, ALE          I/O(1) or memory(0) select; address latch enable
//   ready_in              external READY
//   hold_request          per-requester bus request (level)
//   dma_mem_to_io         per-requester direction: 1 = MEMR+IOW, 0 = IOR+MEMW
//   dma_xfer              granted requester starts one transfer (pulse)
//   cpu_ready             READY to CPU
//   HLDA, hold_ack        bus held / one-hot grant
//   dma_xfer_done         pulse at end of each DMA transfer
//   IOR_N..MEMW_N         bus command strobes, active low
//
// Build option: BUS_CMD_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, lowest index wins).

module bus_command_generator #(
   parameter int NUM_REQ   = 2,
   parameter int CMD_DELAY = 1,
   parameter int IO_WAIT   = 1,
   parameter int MEM_WAIT  = 0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               cpu_clock_posedge,
   input  logic               cpu_clock_negedge,
   input  logic               RD_N,
   input  logic               WR_N,
   input  logic               IO_OR_M,
   input  logic               ALE,
   input  logic               ready_in,
   input  logic [NUM_REQ-1:0] hold_request,
   input  logic [NUM_REQ-1:0] dma_mem_to_io,
   input  logic               dma_xfer,
   output logic               cpu_ready,
   output logic               HLDA,
   output logic [NUM_REQ-1:0] hold_ack,
   output logic               dma_xfer_done,
   output logic               IOR_N,
   output logic               IOW_N,
   output logic               MEMR_N,
   output logic               MEMW_N
);

   localparam int WW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DMA_HOLD =
      ((IO_WAIT > MEM_WAIT) ? IO_WAIT : MEM_WAIT) + 1;

   typedef enum logic [1:0] {
      CPU_OWN,
      WAIT_IDLE,
      GRANT,
      RELEASE
   } state_t;

   state_t state, state_nx;

   logic [WW-1:0] winner;
   logic [WW-1:0] pick;
   logic          win_req;

   logic       cpu_req;
   logic       dly_hit;
   logic       wait_load;
   logic [1:0] dly_cnt;
   logic [3:0] cpu_cmd;
   logic [2:0] wait_cnt;

   logic       dma_armed;
   logic       dma_active;
   logic       dma_dir;
   logic [3:0] dma_cnt;

`ifdef BUS_CMD_ROUND_ROBIN_EN
   logic [WW-1:0] last_grant;

   // Search upward from the last granted index, wrapping to 0.
   always_comb begin
      int j;
      logic found;
      pick  = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = (int'(last_grant) + i) % NUM_REQ;
         if (!found && hold_request[j[WW-1:0]]) begin
            pick  = j[WW-1:0];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         last_grant <= WW'(NUM_REQ - 1);
      else if (state == WAIT_IDLE && state_nx == GRANT)
         last_grant <= winner;
   end
`else
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (hold_request[i[WW-1:0]])
            pick = i[WW-1:0];
      end
   end
`endif

   assign win_req = hold_request[winner];

   always_comb begin
      state_nx = state;
      unique case (state)
         CPU_OWN:
            if (cpu_clock_posedge && |hold_request)
               state_nx = WAIT_IDLE;
         WAIT_IDLE:
            if (cpu_clock_posedge && RD_N && WR_N && !ALE)
               state_nx = GRANT;
         GRANT:
            if (cpu_clock_posedge && !win_req
                && !dma_armed && !dma_active)
               state_nx = RELEASE;
         RELEASE:
            if (cpu_clock_posedge)
               state_nx = CPU_OWN;
         default:
            state_nx = CPU_OWN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= CPU_OWN;
         winner <= '0;
      end else begin
         state <= state_nx;
         if (state == CPU_OWN && state_nx == WAIT_IDLE)
            winner <= pick;
      end
   end

   assign HLDA     = (state == GRANT);
   assign hold_ack = HLDA ? (NUM_REQ'(1) << winner) : '0;

   // Exactly one of RD_N/WR_N low is a legal CPU command.
   assign cpu_req = RD_N ^ WR_N;
   assign dly_hit = (CMD_DELAY == 0) ||
                    (cpu_clock_negedge &&
                     int'(dly_cnt) == CMD_DELAY - 1);
   assign wait_load = !HLDA && cpu_req &&
                      cpu_cmd == 4'b0 && dly_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cpu_cmd  <= '0;
         dly_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         if (HLDA || !cpu_req) begin
            cpu_cmd <= '0;
            dly_cnt <= '0;
         end else if (cpu_cmd == 4'b0) begin
            if (dly_hit)
               cpu_cmd <= { IO_OR_M & ~RD_N,
                            IO_OR_M & ~WR_N,
                           ~IO_OR_M & ~RD_N,
                           ~IO_OR_M & ~WR_N};
            else if (cpu_clock_negedge)
               dly_cnt <= dly_cnt + 2'd1;
         end
         if (wait_load)
            wait_cnt <= IO_OR_M ? 3'(IO_WAIT) : 3'(MEM_WAIT);
         else if (cpu_clock_posedge && wait_cnt != 3'd0)
            wait_cnt <= wait_cnt - 3'd1;
      end
   end

   assign cpu_ready = ready_in & (wait_cnt == 3'd0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dma_armed     <= 1'b0;
         dma_active    <= 1'b0;
         dma_dir       <= 1'b0;
         dma_cnt       <= '0;
         dma_xfer_done <= 1'b0;
      end else begin
         dma_xfer_done <= 1'b0;
         if (!HLDA) begin
            dma_armed  <= 1'b0;
            dma_active <= 1'b0;
         end else begin
            if (dma_xfer && !dma_armed && !dma_active)
               dma_armed <= 1'b1;
            if (dma_armed && cpu_clock_negedge) begin
               dma_armed  <= 1'b0;
               dma_active <= 1'b1;
               dma_dir    <= dma_mem_to_io[winner];
               dma_cnt    <= 4'(DMA_HOLD);
            end
            // ready_in low stretches the transfer.
            if (dma_active && cpu_clock_posedge && ready_in) begin
               if (dma_cnt == 4'd1) begin
                  dma_active    <= 1'b0;
                  dma_xfer_done <= 1'b1;
               end else begin
                  dma_cnt <= dma_cnt - 4'd1;
               end
            end
         end
      end
   end

   assign IOR_N  = ~(cpu_cmd[3] | (dma_active & ~dma_dir));
   assign IOW_N  = ~(cpu_cmd[2] | (dma_active &  dma_dir));
   assign MEMR_N = ~(cpu_cmd[1] | (dma_active &  dma_dir));
   assign MEMW_N = ~(cpu_cmd[0] | (dma_active & ~dma_dir));

endmodule

// File: tb/tb_bus_command_generator.sv
// Testbench for bus_command_generator: table-driven CPU commands,
// strobe scoreboard, and hand-written hold/DMA/reset sequences.

module tb_bus_command_generator;

   localparam int NUM_REQ   = 2;
   localparam int CMD_DELAY = 1;
   localparam int IO_WAIT   = 1;
   localparam int MEM_WAIT  = 0;
   localparam int DMA_HOLD  =
      ((IO_WAIT > MEM_WAIT) ? IO_WAIT : MEM_WAIT) + 1;

   logic clock = 0;
   logic reset_n = 0;
   logic cpu_clock_posedge = 0;
   logic cpu_clock_negedge = 0;
   logic RD_N = 1;
   logic WR_N = 1;
   logic IO_OR_M = 0;
   logic ALE = 0;
   logic ready_in = 1;
   logic dma_xfer = 0;
   logic [NUM_REQ-1:0] hold_request = '0;
   logic [NUM_REQ-1:0] dma_mem_to_io = '0;
   logic cpu_ready, HLDA, dma_xfer_done;
   logic [NUM_REQ-1:0] hold_ack;
   logic IOR_N, IOW_N, MEMR_N, MEMW_N;

   int tests = 0;
   int fails = 0;
   int ph = 0;
   logic [3:0] sb_q[$];

   typedef struct {
      string      name;
      logic       rd_n;
      logic       wr_n;
      logic       io;
      logic [3:0] exp_strb;
      int         exp_wait;
   } vec_t;

   vec_t vecs[5];

   bus_command_generator #(
      .NUM_REQ(NUM_REQ), .CMD_DELAY(CMD_DELAY),
      .IO_WAIT(IO_WAIT), .MEM_WAIT(MEM_WAIT)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_clock_posedge(cpu_clock_posedge),
      .cpu_clock_negedge(cpu_clock_negedge),
      .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M), .ALE(ALE),
      .ready_in(ready_in), .hold_request(hold_request),
      .dma_mem_to_io(dma_mem_to_io), .dma_xfer(dma_xfer),
      .cpu_ready(cpu_ready), .HLDA(HLDA), .hold_ack(hold_ack),
      .dma_xfer_done(dma_xfer_done),
      .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N)
   );

   always #5 clock = ~clock;

   // CPU clock = 4 system clocks: rise pulse at phase 0, fall at phase 2.
   always @(posedge clock) begin
      #1;
      ph = (ph + 1) % 4;
      cpu_clock_posedge = (ph == 0);
      cpu_clock_negedge = (ph == 2);
   end

   function automatic logic [3:0] strb();
      return {IOR_N, IOW_N, MEMR_N, MEMW_N};
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Waits for any strobe to assert, then compares it with the scoreboard.
   task automatic wait_assert(string nm, output int negs);
      logic [3:0] exp;
      negs = 0;
      for (int i = 0; i < 64; i++) begin
         if (cpu_clock_negedge) negs++;
         tick();
         if (strb() != 4'hF) break;
      end
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 4'hF;
      check(nm, 32'(strb()), 32'(exp));
   endtask

   task automatic wait_hlda(string nm, logic exp);
      for (int i = 0; i < 64 && HLDA !== exp; i++) tick();
      check(nm, 32'(HLDA), 32'(exp));
   endtask

   initial begin
      int negs, w, n, p, d;
      logic [NUM_REQ-1:0] rr_exp[3];

      vecs[0] = '{"io_read",   1'b0, 1'b1, 1'b1, 4'b0111, IO_WAIT};
      vecs[1] = '{"io_write",  1'b1, 1'b0, 1'b1, 4'b1011, IO_WAIT};
      vecs[2] = '{"mem_read",  1'b0, 1'b1, 1'b0, 4'b1101, MEM_WAIT};
      vecs[3] = '{"mem_write", 1'b1, 1'b0, 1'b0, 4'b1110, MEM_WAIT};
      vecs[4] = '{"illegal",   1'b0, 1'b0, 1'b1, 4'b1111, 0};

`ifdef BUS_CMD_ROUND_ROBIN_EN
      rr_exp = '{2'b01, 2'b10, 2'b01};
`else
      rr_exp = '{2'b01, 2'b01, 2'b01};
`endif

      repeat (3) tick();
      check("rst_strobes", 32'(strb()), 32'hF);
      check("rst_hlda", 32'(HLDA), 0);
      check("rst_hold_ack", 32'(hold_ack), 0);
      check("rst_done", 32'(dma_xfer_done), 0);
      check("rst_ready", 32'(cpu_ready), 1);
      reset_n = 1;
      repeat (2) tick();

      foreach (vecs[k]) begin
         RD_N = vecs[k].rd_n;
         WR_N = vecs[k].wr_n;
         IO_OR_M = vecs[k].io;
         if (vecs[k].exp_strb != 4'hF) begin
            sb_q.push_back(vecs[k].exp_strb);
            wait_assert(vecs[k].name, negs);
            check({vecs[k].name, "_delay"}, 32'(negs), 32'(CMD_DELAY));
            w = 0;
            for (int i = 0; i < 64 && cpu_ready == 1'b0; i++) begin
               if (cpu_clock_posedge) w++;
               tick();
            end
            check({vecs[k].name, "_wait"}, 32'(w),
                  32'(vecs[k].exp_wait));
            check({vecs[k].name, "_held"}, 32'(strb()),
                  32'(vecs[k].exp_strb));
         end else begin
            n = 0;
            repeat (16) begin
               tick();
               if (strb() != 4'hF) n++;
            end
            check({vecs[k].name, "_no_strobe"}, 32'(n), 0);
         end
         RD_N = 1;
         WR_N = 1;
         tick();
         check({vecs[k].name, "_release"}, 32'(strb()), 32'hF);
         repeat (4) tick();
      end

      // Memory write stretched by external READY low for 3 CPU clocks.
      WR_N = 0;
      IO_OR_M = 0;
      sb_q.push_back(4'b1110);
      wait_assert("memw_ready", negs);
      ready_in = 0;
      n = 0;
      repeat (12) begin
         tick();
         if (!cpu_ready && !MEMW_N) n++;
      end
      ready_in = 1;
      #1;
      check("memw_ready_low_cnt", 32'(n), 12);
      check("memw_ready_back", 32'(cpu_ready), 1);
      WR_N = 1;
      tick();
      check("memw_ready_release", 32'(strb()), 32'hF);
      repeat (4) tick();

      // Hold request during a CPU read: grant waits for RD_N high.
      RD_N = 0;
      IO_OR_M = 1;
      sb_q.push_back(4'b0111);
      wait_assert("hold_rd", negs);
      hold_request = 2'b10;
      n = 0;
      repeat (16) begin
         tick();
         if (HLDA) n++;
      end
      check("hold_no_early_hlda", 32'(n), 0);
      RD_N = 1;
      wait_hlda("hold_hlda", 1'b1);
      check("hold_ack_ch1", 32'(hold_ack), 32'b10);
      check("hold_strobes_idle", 32'(strb()), 32'hF);
      RD_N = 0;
      n = 0;
      repeat (12) begin
         tick();
         if (strb() != 4'hF) n++;
      end
      check("hold_cpu_blocked", 32'(n), 0);
      check("hold_cpu_ready", 32'(cpu_ready), 1);
      RD_N = 1;
      tick();

      // DMA memory-to-I/O transfer on requester 1.
      dma_mem_to_io = 2'b10;
      sb_q.push_back(4'b1001);
      dma_xfer = 1;
      tick();
      dma_xfer = 0;
      wait_assert("dma_pair", negs);
      p = 0;
      d = 0;
      for (int i = 0; i < 64 && strb() != 4'hF; i++) begin
         if (cpu_clock_posedge) p++;
         tick();
         if (dma_xfer_done) d++;
      end
      check("dma_hold_posedges", 32'(p), 32'(DMA_HOLD));
      check("dma_done_with_end", 32'(dma_xfer_done), 1);
      repeat (4) begin
         tick();
         if (dma_xfer_done) d++;
      end
      check("dma_done_pulses", 32'(d), 1);
      hold_request = '0;
      wait_hlda("dma_release", 1'b0);
      check("dma_release_ack", 32'(hold_ack), 0);
      repeat (8) tick();

      // Repeated simultaneous requests.
      for (int k = 0; k < 3; k++) begin
         hold_request = 2'b11;
         wait_hlda($sformatf("arb%0d_hlda", k), 1'b1);
         check($sformatf("arb%0d_winner", k), 32'(hold_ack),
               32'(rr_exp[k]));
         hold_request = '0;
         wait_hlda($sformatf("arb%0d_drop", k), 1'b0);
         repeat (8) tick();
      end

      // Reset in the middle of a DMA transfer.
      hold_request = 2'b01;
      dma_mem_to_io = 2'b00;
      wait_hlda("rstdma_hlda", 1'b1);
      sb_q.push_back(4'b0110);
      dma_xfer = 1;
      tick();
      dma_xfer = 0;
      wait_assert("rstdma_pair", negs);
      tick();
      #1;
      reset_n = 0;
      #1;
      check("rstdma_strobes", 32'(strb()), 32'hF);
      check("rstdma_hlda", 32'(HLDA), 0);
      check("rstdma_ack", 32'(hold_ack), 0);
      check("rstdma_done", 32'(dma_xfer_done), 0);
      check("rstdma_ready", 32'(cpu_ready), 1);
      hold_request = '0;
      repeat (2) tick();
      reset_n = 1;
      repeat (4) tick();
      RD_N = 0;
      IO_OR_M = 1;
      sb_q.push_back(4'b0111);
      wait_assert("post_rst_read", negs);
      check("post_rst_delay", 32'(negs), 32'(CMD_DELAY));
      RD_N = 1;
      tick();
      check("post_rst_release", 32'(strb()), 32'hF);
      check("sb_empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
